// File: rtl/lbp_pkg.sv
// Shared constants and FSM state type for the LBP neighbourhood fetch unit.
package lbp_pkg;

  localparam int IMG_W    = 128;
  localparam int AW       = 14;
  localparam int SLOT_CNT = 9;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/lbp_fetch_if.sv
// Gray-memory read port and LBP datapath tag bus driven by lbp_fetch.
interface lbp_fetch_if import lbp_pkg::*; #(
  parameter int AW = lbp_pkg::AW
);

  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [3:0]    cnt_o;
  logic          white_o;
  logic [AW-1:0] addr_o;
  logic          finish_o;

  modport master (
    input  gray_ready,
    output gray_req, gray_addr, cnt_o, white_o, addr_o, finish_o
  );

  modport slave (
    output gray_ready,
    input  gray_req, gray_addr, cnt_o, white_o, addr_o, finish_o
  );

endinterface

// File: rtl/lbp_nbr_addr.sv
// Combinational 3x3 window address generator: slot 0 is the centre, 1..8 walk the
// neighbours in LBP bit order. Arithmetic wraps at AW bits.
module lbp_nbr_addr import lbp_pkg::*; #(
  parameter int IMG_W = lbp_pkg::IMG_W,
  parameter int AW    = lbp_pkg::AW,
  localparam int RW   = $clog2(IMG_W)
) (
  input  logic [RW-1:0] row,
  input  logic [RW-1:0] col,
  input  logic [3:0]    slot,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] STRIDE = AW'(IMG_W);
  localparam logic [AW-1:0] ONE    = AW'(1);

  logic [AW-1:0] center;

  always_comb begin
    center = AW'(row) * STRIDE + AW'(col);
    case (slot)
      4'd1:    addr = center - STRIDE - ONE;
      4'd2:    addr = center - STRIDE;
      4'd3:    addr = center - STRIDE + ONE;
      4'd4:    addr = center - ONE;
      4'd5:    addr = center + ONE;
      4'd6:    addr = center + STRIDE - ONE;
      4'd7:    addr = center + STRIDE;
      4'd8:    addr = center + STRIDE + ONE;
      default: addr = center;
    endcase
  end

endmodule

// File: rtl/lbp_fetch.sv
// Raster-scan fetch sequencer for a 3x3 LBP operator. Define LBP_SKIP_BORDER_EN to
// scan only the interior pixels instead of emitting one white slot per border pixel.
module lbp_fetch import lbp_pkg::*; #(
  parameter int IMG_W = lbp_pkg::IMG_W,
  parameter int AW    = lbp_pkg::AW
) (
  input  logic clk,
  input  logic rst,
  lbp_fetch_if.master bus
);

  localparam int RW = $clog2(IMG_W);
  localparam logic [3:0]    LAST_SLOT = 4'(SLOT_CNT - 1);
  localparam logic [AW-1:0] STRIDE    = AW'(IMG_W);
`ifdef LBP_SKIP_BORDER_EN
  localparam logic [RW-1:0] FIRST_IDX = RW'(1);
  localparam logic [RW-1:0] LAST_IDX  = RW'(IMG_W - 2);
`else
  localparam logic [RW-1:0] FIRST_IDX = '0;
  localparam logic [RW-1:0] LAST_IDX  = RW'(IMG_W - 1);
`endif

  state_t        state;
  logic [RW-1:0] row, col;
  logic [3:0]    slot;
  logic          drain_cnt;
  logic [3:0]    p_cnt;
  logic          p_white;
  logic [AW-1:0] p_addr;
  logic [AW-1:0] nbr_addr, pix_addr;
  logic          border, last_slot, last_pixel;

  lbp_nbr_addr #(.IMG_W(IMG_W), .AW(AW)) u_nbr (
    .row  (row),
    .col  (col),
    .slot (slot),
    .addr (nbr_addr)
  );

`ifdef LBP_SKIP_BORDER_EN
  assign border = 1'b0;
`else
  assign border = (row == '0) || (col == '0) ||
                  (row == RW'(IMG_W - 1)) || (col == RW'(IMG_W - 1));
`endif

  assign pix_addr   = AW'(row) * STRIDE + AW'(col);
  assign last_slot  = border || (slot == LAST_SLOT);
  assign last_pixel = (row == LAST_IDX) && (col == LAST_IDX);

  // p_* is the tag stage that travels with gray_addr; it is copied to the outputs one
  // cycle later so the tag lines up with gray_data. The final slot's tag therefore
  // surfaces during DRAIN, after which white_o settles to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      slot         <= '0;
      drain_cnt    <= 1'b0;
      p_cnt        <= '0;
      p_white      <= 1'b0;
      p_addr       <= '0;
      bus.gray_req  <= 1'b0;
      bus.gray_addr <= '0;
      bus.cnt_o     <= '0;
      bus.white_o   <= 1'b0;
      bus.addr_o    <= '0;
      bus.finish_o  <= 1'b0;
    end else begin
      bus.cnt_o   <= p_cnt;
      bus.white_o <= p_white;
      bus.addr_o  <= p_addr;
      case (state)
        IDLE: begin
          if (bus.gray_ready) begin
            state <= FETCH;
            row   <= FIRST_IDX;
            col   <= FIRST_IDX;
            slot  <= '0;
          end
        end
        FETCH: begin
          bus.gray_req <= !border;
          if (!border) bus.gray_addr <= nbr_addr;
          p_cnt   <= border ? 4'd0 : slot;
          p_white <= border;
          p_addr  <= pix_addr;
          if (last_slot) begin
            slot <= '0;
            if (last_pixel) begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end else if (col == LAST_IDX) begin
              col <= FIRST_IDX;
              row <= row + RW'(1);
            end else begin
              col <= col + RW'(1);
            end
          end else begin
            slot <= slot + 4'd1;
          end
        end
        DRAIN: begin
          bus.gray_req <= 1'b0;
          p_white      <= 1'b0;
          drain_cnt    <= 1'b1;
          if (drain_cnt) begin
            state        <= DONE;
            bus.finish_o <= 1'b1;
          end
        end
        default: begin
          bus.gray_req <= 1'b0;
          p_white      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_fetch.sv
// Scoreboard bench for lbp_fetch on an 8x8 image; honours LBP_SKIP_BORDER_EN.
module tb_lbp_fetch;

  localparam int W  = 8;
  localparam int AW = 6;
`ifdef LBP_SKIP_BORDER_EN
  localparam int FIRST = 1, LAST = W - 2, N_FETCH = 324, LAST_ADDR = 54, LAST_CNT = 8;
`else
  localparam int FIRST = 0, LAST = W - 1, N_FETCH = 352, LAST_ADDR = 63, LAST_CNT = 0;
`endif

  typedef struct {
    logic [3:0]    cnt;
    logic [AW-1:0] addr;
  } slot_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  bit   req_d  = 1'b0;

  logic [AW-1:0] exp_req[$];
  slot_t         exp_slot[$];
  logic [AW-1:0] exp_border[$];
  logic [AW-1:0] seen_addr[$];

  int dr[9] = '{0, -1, -1, -1, 0, 0, 1, 1, 1};
  int dc[9] = '{0, -1, 0, 1, -1, 1, -1, 0, 1};
  int first_pix[9] = '{9, 0, 1, 2, 8, 10, 16, 17, 18};

  lbp_fetch_if #(.AW(AW)) bus ();

  lbp_fetch #(.IMG_W(W), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic queue_underflow(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: DUT produced an output with nothing expected", name);
  endtask

  function automatic bit is_border(input int r, input int c);
    return (r == 0) || (c == 0) || (r == W - 1) || (c == W - 1);
  endfunction

  // Expected scan, built from the window definition rather than from offsets.
  task automatic apply_stimulus();
    for (int r = FIRST; r <= LAST; r++) begin
      for (int c = FIRST; c <= LAST; c++) begin
        logic [AW-1:0] pa;
        pa = AW'(r * W + c);
        if (is_border(r, c)) begin
          exp_border.push_back(pa);
        end else begin
          for (int k = 0; k < 9; k++) begin
            exp_req.push_back(AW'((r + dr[k]) * W + (c + dc[k])));
            exp_slot.push_back(slot_t'{cnt: 4'(k), addr: pa});
          end
        end
      end
    end
  endtask

  function automatic int cycles_before(input int r0, input int c0);
    int n = 0;
    for (int r = FIRST; r <= LAST; r++) begin
      for (int c = FIRST; c <= LAST; c++) begin
        if (r == r0 && c == c0) return n;
        n += is_border(r, c) ? 1 : 9;
      end
    end
    return n;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      req_d = 1'b0;
    end else begin
      if (req_d) begin
        if (exp_slot.size() == 0) queue_underflow("slot_tag");
        else begin
          slot_t e;
          e = exp_slot.pop_front();
          check_output("cnt_o", bus.cnt_o, e.cnt);
          check_output("addr_o", bus.addr_o, e.addr);
          check_output("white_o_interior", bus.white_o, 0);
        end
      end
      if (bus.white_o) begin
        if (exp_border.size() == 0) queue_underflow("border_slot");
        else begin
          check_output("border_addr_o", bus.addr_o, exp_border.pop_front());
          check_output("border_cnt_o", bus.cnt_o, 0);
        end
      end
      if (bus.gray_req) begin
        seen_addr.push_back(bus.gray_addr);
        if (exp_req.size() == 0) queue_underflow("gray_req");
        else check_output("gray_addr", bus.gray_addr, exp_req.pop_front());
      end
      req_d = bus.gray_req;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_gray_req"}, bus.gray_req, 0);
    check_output({tag, "_gray_addr"}, bus.gray_addr, 0);
    check_output({tag, "_cnt_o"}, bus.cnt_o, 0);
    check_output({tag, "_white_o"}, bus.white_o, 0);
    check_output({tag, "_addr_o"}, bus.addr_o, 0);
    check_output({tag, "_finish_o"}, bus.finish_o, 0);
  endtask

  task automatic run_scan(input string tag);
    int n;
    apply_stimulus();
    seen_addr.delete();
    @(negedge clk);
    bus.gray_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (n == 6) bus.gray_ready = 1'b0;
    end while (!bus.finish_o && n < N_FETCH + 50);
    check_output({tag, "_finish_latency"}, n, N_FETCH + 3);
    @(negedge clk);
    check_output({tag, "_left_req"}, exp_req.size(), 0);
    check_output({tag, "_left_slot"}, exp_slot.size(), 0);
    check_output({tag, "_left_border"}, exp_border.size(), 0);
    check_output({tag, "_done_gray_req"}, bus.gray_req, 0);
    check_output({tag, "_done_white_o"}, bus.white_o, 0);
    check_output({tag, "_done_cnt_o"}, bus.cnt_o, LAST_CNT);
    check_output({tag, "_done_addr_o"}, bus.addr_o, LAST_ADDR);
    bus.gray_ready = 1'b1;
    repeat (5) @(negedge clk);
    check_output({tag, "_done_terminal"}, bus.finish_o, 1);
    check_output({tag, "_done_no_req"}, bus.gray_req, 0);
    bus.gray_ready = 1'b0;
  endtask

  initial begin
    int k;
    bus.gray_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    repeat (20) @(negedge clk);
    check_output("idle_gray_req", bus.gray_req, 0);
    check_output("idle_finish_o", bus.finish_o, 0);

    run_scan("scan1");
    for (int i = 0; i < 9; i++) begin
      if (i < seen_addr.size()) check_output($sformatf("pixel11_addr%0d", i), seen_addr[i], first_pix[i]);
      else queue_underflow($sformatf("pixel11_missing%0d", i));
    end

    // Abort in the middle of pixel (5,5) slot 4, then require a clean restart.
    rst = 1'b1;
    @(negedge clk);
    exp_req.delete();
    exp_slot.delete();
    exp_border.delete();
    rst = 1'b0;
    apply_stimulus();
    @(negedge clk);
    bus.gray_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.gray_ready = 1'b0;
    k = cycles_before(5, 5) + 4;
    repeat (k) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    exp_req.delete();
    exp_slot.delete();
    exp_border.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_output("abort_idle_gray_req", bus.gray_req, 0);

    run_scan("scan2");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/lbp_fetch.md
LBP_FETCH -- requirements
Module: lbp_fetch

Interface
REQ-001 Parameters: IMG_W default 128, image width/height in pixels (square); AW default 14, address width, equal to log2(IMG_W*IMG_W).
REQ-002 Clock domain: one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  clock; all state on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: gray_ready  input  1  level; source image is loaded and readable.
REQ-006 Port: gray_req  output  1  read strobe to gray memory.
REQ-007 Port: gray_addr  output  AW  read address, row-major (row*IMG_W+col).
REQ-008 Port: cnt_o  output  4  window slot tag to the LBP datapath: 0 = centre, 1..8 = neighbour.
REQ-009 Port: white_o  output  1  current pixel is a border pixel; LBP result is forced to 0.
REQ-010 Port: addr_o  output  AW  output-image address of the pixel that owns the current slot.
REQ-011 Port: finish_o  output  1  level; whole image processed and pipeline drained.

Function
REQ-012 FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE->FETCH on first cycle gray_ready=1.
- FETCH->DRAIN after the last slot of the last pixel.
- DRAIN->DONE after exactly 2 cycles.
- DONE is terminal until reset.
REQ-013 Scan order: raster, row 0..IMG_W-1, col 0..IMG_W-1; row/col counters each log2(IMG_W) bits; col wraps to 0 with row+1.
REQ-014 Interior pixel (1<=row,col<=IMG_W-2): 9 consecutive FETCH cycles, slot 0..8, gray_req=1 in each.
REQ-015 Slot addresses: slot 0 = (r,c); slots 1..8 = (r-1,c-1),(r-1,c),(r-1,c+1),(r,c-1),(r,c+1),(r+1,c-1),(r+1,c),(r+1,c+1); slot k maps to LBP bit k-1.
REQ-016 Border pixel (row or col in {0,IMG_W-1}): one FETCH cycle, gray_req=0, gray_addr unchanged from the previous cycle.
REQ-017 gray_addr/gray_req are registered; gray_data is valid one cycle after gray_req.
REQ-018 cnt_o, white_o and addr_o are registered and delayed one cycle after the gray_addr of the same slot, so they align with the returned gray_data.
REQ-019 cnt_o equals the slot index. For a border slot: cnt_o=0, white_o=1. Otherwise white_o=0.
REQ-020 addr_o is constant over all slots of one pixel.
REQ-021 Address arithmetic wraps modulo 2^AW; neighbour offsets are ±1 and ±IMG_W, computed at AW bits.
REQ-022 gray_ready is sampled only in IDLE; deassertion during FETCH is ignored.
REQ-023 In DRAIN and DONE: gray_req=0 and white_o=0. cnt_o and addr_o hold their last values.
REQ-024 finish_o=1 only in DONE.

Reset
REQ-025 On rst: state=IDLE; row=col=slot=0; gray_req=0, gray_addr=0, cnt_o=0, white_o=0, addr_o=0, finish_o=0.
REQ-026 rst mid-scan aborts immediately; the scan restarts from pixel (0,0) on the next gray_ready.

Configuration
REQ-027 Macro LBP_SKIP_BORDER_EN.
- Defined: the scan covers only rows and cols 1..IMG_W-2 and starts at (1,1); border slots are never emitted and white_o is constant 0.
- Undefined: border pixels are emitted per REQ-016.

Structure
REQ-028 Shared package lbp_pkg holds IMG_W, AW, the FSM state enum and the slot count constant 9.
REQ-029 Neighbour address generation is in sub-module lbp_nbr_addr: combinational; inputs row, col, slot; output addr.

Verification
REQ-030 Reset then gray_ready=1 -> first gray_req at (0,0) is 0 and white_o=1 with addr_o=0 one cycle later.
REQ-031 Pixel (1,1), IMG_W=128 -> gray_addr sequence 129,0,1,2,128,130,256,257,258 and cnt_o 0..8 lagging by one cycle.
REQ-032 Full scan, macro undefined -> 126*126*9+508=143392 FETCH cycles; finish_o rises 2 cycles after the last slot.
REQ-033 Full scan, LBP_SKIP_BORDER_EN defined -> 142884 FETCH cycles, white_o never 1, first addr_o=129, last addr_o=16254.
REQ-034 rst pulsed during pixel (5,7) slot 4 -> all outputs at 0 immediately; next gray_ready restarts at pixel (0,0), or (1,1) with the macro defined.
REQ-035 gray_ready dropped mid-scan -> scan continues unchanged; gray_ready held 0 after reset -> gray_req stays 0 indefinitely.
